c5_mem_responder: RTL and testbench

//  Memory-side responder for the c5_cpu bus: answers the CPU's address/byte-enable/write-data

---
 rtl/c5_mem_responder.sv | 160 ++++++++++++++++
 tb/tb_c5_mem_responder.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/c5_mem_responder.sv
// Memory-side responder for the c5_cpu bus: zero-wait on-chip RAM, a GPIO register pair,
// and a slow external bus reached through a three-state wait-state FSM.
module c5_mem_responder #(
  parameter int RAM_AW   = 10,
  parameter int EXT_WAIT = 3
) (
  input  logic        I_clk,
  input  logic        I_rst_n,
  input  logic [29:0] I_address_next,
  input  logic [29:0] I_address,
  input  logic [3:0]  I_byte_we,
  input  logic [31:0] I_data_w,
  output logic [31:0] O_data_r,
  output logic        O_mem_pause,
  output logic [31:0] O_gpio_out,
  input  logic [31:0] I_gpio_in,
  output logic        O_ext_req,
  output logic [29:0] O_ext_addr,
  output logic [3:0]  O_ext_byte_we,
  output logic [31:0] O_ext_data_w,
  input  logic [31:0] I_ext_data_r
);

  typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_DONE} state_e;

  localparam logic [3:0] REG_RAM  = 4'h0;
  localparam logic [3:0] REG_GPIO = 4'h2;
  localparam logic [3:0] REG_EXT  = 4'h4;

  logic [3:0] region;
  assign region = I_address[29:26];

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [29:0] ext_addr_q, ext_addr_d;
  logic [3:0]  ext_we_q, ext_we_d;
  logic [31:0] ext_wdata_q, ext_wdata_d;
  logic [31:0] ext_rdata_q, ext_rdata_d;
  logic [31:0] ram_rdata_q, ram_rdata_d;
  logic [31:0] gpio_out_q, gpio_out_d;
  logic [31:0] gpio_s1_q, gpio_s2_q;
  logic        pause, ext_req;

  logic [31:0]       ram_mem [2**RAM_AW];
  logic [RAM_AW-1:0] ram_raddr, ram_waddr;
  logic              ram_we, gpio_we;

  logic unused_addr_next;
  assign unused_addr_next = ^I_address_next[29:RAM_AW];

  // External access FSM; pause is raised combinationally in the IDLE cycle that sees the access
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ext_addr_d  = ext_addr_q;
    ext_we_d    = ext_we_q;
    ext_wdata_d = ext_wdata_q;
    ext_rdata_d = ext_rdata_q;
    pause       = 1'b0;
    ext_req     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (region == REG_EXT) begin
          pause       = 1'b1;
          ext_addr_d  = I_address;
          ext_we_d    = I_byte_we;
          ext_wdata_d = I_data_w;
          cnt_d       = 4'(EXT_WAIT);
          state_d     = ST_BUSY;
        end
      end
      ST_BUSY: begin
        pause   = 1'b1;
        ext_req = 1'b1;
        cnt_d   = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          ext_rdata_d = I_ext_data_r;
          state_d     = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // RAM: read register follows the next address unless the CPU is held, with write bypass
  assign ram_we    = (region == REG_RAM) && (I_byte_we != 4'h0) && !pause;
  assign ram_waddr = I_address[RAM_AW-1:0];
  assign ram_raddr = pause ? I_address[RAM_AW-1:0] : I_address_next[RAM_AW-1:0];

  always_comb begin
    ram_rdata_d = ram_mem[ram_raddr];
    for (int b = 0; b < 4; b++)
      if (ram_we && (ram_raddr == ram_waddr) && I_byte_we[b])
        ram_rdata_d[8*b +: 8] = I_data_w[8*b +: 8];
  end

  always_ff @(posedge I_clk) begin
    for (int b = 0; b < 4; b++)
      if (ram_we && I_byte_we[b])
        ram_mem[ram_waddr][8*b +: 8] <= I_data_w[8*b +: 8];
  end

  assign gpio_we = (region == REG_GPIO) && (I_address[25:0] == 26'd0) && !pause;

  always_comb begin
    gpio_out_d = gpio_out_q;
    for (int b = 0; b < 4; b++)
      if (gpio_we && I_byte_we[b])
        gpio_out_d[8*b +: 8] = I_data_w[8*b +: 8];
  end

  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      ext_addr_q  <= '0;
      ext_we_q    <= '0;
      ext_wdata_q <= '0;
      ext_rdata_q <= '0;
      ram_rdata_q <= '0;
      gpio_out_q  <= '0;
      gpio_s1_q   <= '0;
      gpio_s2_q   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ext_addr_q  <= ext_addr_d;
      ext_we_q    <= ext_we_d;
      ext_wdata_q <= ext_wdata_d;
      ext_rdata_q <= ext_rdata_d;
      ram_rdata_q <= ram_rdata_d;
      gpio_out_q  <= gpio_out_d;
      gpio_s1_q   <= I_gpio_in;
      gpio_s2_q   <= gpio_s1_q;
    end
  end

  always_comb begin
    O_data_r = '0;
    case (region)
      REG_RAM:  O_data_r = ram_rdata_q;
      REG_GPIO: begin
        if (I_address[25:0] == 26'd0)      O_data_r = gpio_out_q;
        else if (I_address[25:0] == 26'd1) O_data_r = gpio_s2_q;
      end
      REG_EXT:  O_data_r = ext_rdata_q;
      default:  O_data_r = '0;
    endcase
  end

  // Gate with reset so an ext address present during reset cannot stall the CPU
  assign O_mem_pause   = pause & I_rst_n;
  assign O_ext_req     = ext_req;
  assign O_ext_addr    = ext_addr_q;
  assign O_ext_byte_we = ext_we_q;
  assign O_ext_data_w  = ext_wdata_q;
  assign O_gpio_out    = gpio_out_q;

endmodule

// File: tb/tb_c5_mem_responder.sv
// Directed bench for c5_mem_responder: RAM, byte lanes, GPIO sync, external FSM, reset abort.
module tb_c5_mem_responder;
  logic        I_clk = 1'b0;
  logic        I_rst_n;
  logic [29:0] I_address_next, I_address;
  logic [3:0]  I_byte_we;
  logic [31:0] I_data_w, O_data_r, O_gpio_out, I_gpio_in, O_ext_data_w, I_ext_data_r;
  logic        O_mem_pause, O_ext_req;
  logic [29:0] O_ext_addr;
  logic [3:0]  O_ext_byte_we;

  int checks = 0;
  int failures = 0;

  c5_mem_responder #(.RAM_AW(10), .EXT_WAIT(3)) dut (
    .I_clk(I_clk), .I_rst_n(I_rst_n), .I_address_next(I_address_next), .I_address(I_address),
    .I_byte_we(I_byte_we), .I_data_w(I_data_w), .O_data_r(O_data_r), .O_mem_pause(O_mem_pause),
    .O_gpio_out(O_gpio_out), .I_gpio_in(I_gpio_in), .O_ext_req(O_ext_req), .O_ext_addr(O_ext_addr),
    .O_ext_byte_we(O_ext_byte_we), .O_ext_data_w(O_ext_data_w), .I_ext_data_r(I_ext_data_r)
  );

  always #5 I_clk = ~I_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set(input logic [31:0] a, input logic [31:0] n, input logic [3:0] we,
                     input logic [31:0] d);
    I_address      = a[31:2];
    I_address_next = n[31:2];
    I_byte_we      = we;
    I_data_w       = d;
  endtask

  task automatic cyc();
    @(posedge I_clk);
    #1;
  endtask

  // One external read from IDLE to DONE; caller is just past a rising edge
  task automatic ext_read(input string tag, input logic [31:0] a, input logic [31:0] d);
    int pc = 0;
    int rc = 0;
    logic done = 1'b0;
    logic [31:0] ea = '0;
    logic [31:0] dr = '0;
    set(a, a + 32'd4, 4'h0, 32'h0);
    I_ext_data_r = d;
    for (int i = 0; i < 20; i++) begin
      @(negedge I_clk);
      if (O_mem_pause) pc++;
      if (O_ext_req) begin
        rc++;
        ea = {2'b00, O_ext_addr};
      end
      if (!O_mem_pause) begin
        done = 1'b1;
        dr = O_data_r;
        break;
      end
      cyc();
    end
    chk({tag, "_done"}, {31'd0, done}, 32'd1);
    chk({tag, "_pause_len"}, pc, 32'd4);
    chk({tag, "_req_len"}, rc, 32'd3);
    chk({tag, "_ext_addr"}, ea, {2'b00, a[31:2]});
    chk({tag, "_rdata"}, dr, d);
    cyc();
    set(32'h0, 32'h0, 4'h0, 32'h0);
  endtask

  initial begin
    int phase, gap, req1, req2;
    logic ok1, ok2;
    I_rst_n = 1'b0;
    set(32'h0, 32'h0, 4'h0, 32'h0);
    I_gpio_in = '0;
    I_ext_data_r = '0;
    repeat (2) @(posedge I_clk);
    @(negedge I_clk);
    chk("rst_pause", {31'd0, O_mem_pause}, 32'd0);
    chk("rst_req", {31'd0, O_ext_req}, 32'd0);
    chk("rst_gpio", O_gpio_out, 32'h0);
    chk("rst_data_r", O_data_r, 32'h0);
    chk("rst_ext_addr", {2'b00, O_ext_addr}, 32'h0);
    chk("rst_ext_wdata", O_ext_data_w, 32'h0);
    I_rst_n = 1'b1;
    cyc();

    // RAM write then zero-wait read-back
    set(32'h10, 32'h10, 4'hF, 32'hDEADBEEF);
    @(negedge I_clk); chk("ram_wr_pause", {31'd0, O_mem_pause}, 32'd0);
    cyc();
    set(32'h10, 32'h10, 4'h0, 32'h0);
    @(negedge I_clk);
    chk("ram_rd", O_data_r, 32'hDEADBEEF);
    chk("ram_rd_pause", {31'd0, O_mem_pause}, 32'd0);
    cyc();

    // Byte lane write, then aliased write to byte 1
    set(32'h10, 32'h10, 4'h1, 32'h000000AA);
    cyc();
    set(32'h10, 32'h10, 4'h0, 32'h0);
    @(negedge I_clk); chk("ram_lane0", O_data_r, 32'hDEADBEAA);
    cyc();
    set(32'h1010, 32'h10, 4'h2, 32'h00001100);
    cyc();
    set(32'h10, 32'h10, 4'h0, 32'h0);
    @(negedge I_clk); chk("ram_alias", O_data_r, 32'hDEAD11AA);
    cyc();

    // GPIO output register, input synchroniser, read-only word 1, unmapped word
    set(32'h20000000, 32'h20000000, 4'hF, 32'h12345678);
    cyc();
    set(32'h20000000, 32'h20000004, 4'h0, 32'h0);
    @(negedge I_clk);
    chk("gpio_out", O_gpio_out, 32'h12345678);
    chk("gpio_rd0", O_data_r, 32'h12345678);
    cyc();
    I_gpio_in = 32'hCAFE0001;
    set(32'h20000004, 32'h20000004, 4'h0, 32'h0);
    @(negedge I_clk); chk("gpio_sync0", O_data_r, 32'h0);
    cyc();
    @(negedge I_clk); chk("gpio_sync1", O_data_r, 32'h0);
    cyc();
    @(negedge I_clk); chk("gpio_sync2", O_data_r, 32'hCAFE0001);
    cyc();
    set(32'h20000004, 32'h20000000, 4'hF, 32'hFFFFFFFF);
    cyc();
    set(32'h20000000, 32'h20000000, 4'h0, 32'h0);
    @(negedge I_clk);
    chk("gpio_ro_out", O_gpio_out, 32'h12345678);
    chk("gpio_ro_rd", O_data_r, 32'h12345678);
    cyc();
    set(32'h20000008, 32'h20000008, 4'h0, 32'h0);
    @(negedge I_clk); chk("gpio_unmapped", O_data_r, 32'h0);
    cyc();

    ext_read("ext_rd", 32'h40000008, 32'h55AA55AA);

    // Back-to-back external writes
    set(32'h40000100, 32'h40000104, 4'hF, 32'h11111111);
    phase = 0; gap = 0; req1 = 0; req2 = 0; ok1 = 1'b1; ok2 = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge I_clk);
      if (phase == 0) begin
        if (O_ext_req) begin
          req1++;
          if (O_ext_addr !== 30'h10000040 || O_ext_byte_we !== 4'hF || O_ext_data_w !== 32'h11111111)
            ok1 = 1'b0;
        end
        if (!O_mem_pause) begin phase = 1; gap = 1; end
      end else if (phase == 1) begin
        if (O_mem_pause) phase = 2;
        else gap++;
        if (O_ext_req) gap += 100;
      end
      if (phase == 2) begin
        if (O_ext_req) begin
          req2++;
          if (O_ext_addr !== 30'h10000041 || O_ext_byte_we !== 4'h3 || O_ext_data_w !== 32'h22220000)
            ok2 = 1'b0;
        end
        if (!O_mem_pause) begin phase = 3; break; end
      end
      cyc();
      if (phase >= 1) set(32'h40000104, 32'h40000108, 4'h3, 32'h22220000);
    end
    chk("b2b_done", phase, 32'd3);
    chk("b2b_gap", gap, 32'd1);
    chk("b2b_req1", req1, 32'd3);
    chk("b2b_req2", req2, 32'd3);
    chk("b2b_fields1", {31'd0, ok1}, 32'd1);
    chk("b2b_fields2", {31'd0, ok2}, 32'd1);
    cyc();
    set(32'h0, 32'h0, 4'h0, 32'h0);

    // Reset during BUSY
    set(32'h20000000, 32'h20000000, 4'hF, 32'hA5A5A5A5);
    cyc();
    set(32'h40000008, 32'h4000000C, 4'h0, 32'h0);
    I_ext_data_r = 32'h0BADF00D;
    @(negedge I_clk); chk("abort_idle_pause", {31'd0, O_mem_pause}, 32'd1);
    cyc();
    @(negedge I_clk); chk("abort_busy_req", {31'd0, O_ext_req}, 32'd1);
    #1 I_rst_n = 1'b0;
    #1;
    chk("abort_pause", {31'd0, O_mem_pause}, 32'd0);
    chk("abort_req", {31'd0, O_ext_req}, 32'd0);
    chk("abort_gpio", O_gpio_out, 32'h0);
    chk("abort_ext_addr", {2'b00, O_ext_addr}, 32'h0);
    chk("abort_data_r", O_data_r, 32'h0);
    cyc();
    I_rst_n = 1'b1;
    ext_read("ext_after_rst", 32'h40000008, 32'h0BADF00D);
    set(32'h80000000, 32'h80000000, 4'h0, 32'h0);
    @(negedge I_clk);
    chk("unmapped_rd", O_data_r, 32'h0);
    chk("unmapped_pause", {31'd0, O_mem_pause}, 32'd0);
    cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
